// File: rtl/spi_chan_pkg.sv
// spi_chan_pkg: shared word width, default marker words and RX state encoding
// for the SPI packet channel controller.
package spi_chan_pkg;
   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] DEF_START_WORD = 16'h09BB;
   localparam logic [WORD_W-1:0] DEF_IDLE_WORD = 16'h0000;
   typedef enum logic [1:0] {RX_IDLE, RX_LEN, RX_PAYLOAD, RX_DROP} rx_state_t;
endpackage

// File: rtl/spi_chan_ctrl_if.sv
// spi_chan_ctrl_if: word-level signals between the SPI slave core, the FIFOs
// and the packet controller; the controller takes the slave modport.
interface spi_chan_ctrl_if;
   import spi_chan_pkg::*;
   logic [WORD_W-1:0] rx_word;
   logic              rx_word_vld;
   logic [WORD_W-1:0] rxf_data;
   logic              rxf_wr;
   logic              rxf_sop;
   logic              rxf_eop;
   logic              rxf_full;
   logic              rx_drop;
   logic [WORD_W-1:0] pkt_cnt;
   logic              tx_req;
   logic [WORD_W-1:0] txa_data;
   logic              txa_empty;
   logic              txa_rd;
   logic [WORD_W-1:0] txb_data;
   logic              txb_empty;
   logic              txb_rd;
   logic [WORD_W-1:0] tx_word;
   modport slave (
      input  rx_word, rx_word_vld, rxf_full, tx_req, txa_data, txa_empty, txb_data, txb_empty,
      output rxf_data, rxf_wr, rxf_sop, rxf_eop, rx_drop, pkt_cnt, txa_rd, txb_rd, tx_word
   );
   modport master (
      output rx_word, rx_word_vld, rxf_full, tx_req, txa_data, txa_empty, txb_data, txb_empty,
      input  rxf_data, rxf_wr, rxf_sop, rxf_eop, rx_drop, pkt_cnt, txa_rd, txb_rd, tx_word
   );
endinterface

// File: rtl/spi_tx_arb.sv
// spi_tx_arb: 2:1 round-robin arbiter between the data (A) and control (B)
// FIFOs, registering the granted head word as the next MISO word.
module spi_tx_arb import spi_chan_pkg::*; #(
   parameter logic [WORD_W-1:0] IDLE_WORD = DEF_IDLE_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [WORD_W-1:0] a_data_i,
   input  logic              a_empty_i,
   input  logic [WORD_W-1:0] b_data_i,
   input  logic              b_empty_i,
   output logic              a_rd_o,
   output logic              b_rd_o,
   output logic [WORD_W-1:0] word_o
);
   logic              last_b_q, last_b_d;
   logic [WORD_W-1:0] word_q, word_d;
   // last_b_q set means B was granted last, so A wins the next contested request
   always_comb begin
      a_rd_o   = req_i && !a_empty_i && (b_empty_i || last_b_q);
      b_rd_o   = req_i && !b_empty_i && (a_empty_i || !last_b_q);
      last_b_d = a_rd_o ? 1'b0 : b_rd_o ? 1'b1 : last_b_q;
      word_d   = a_rd_o ? a_data_i : b_rd_o ? b_data_i : req_i ? IDLE_WORD : word_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_b_q <= 1'b1;
         word_q   <= IDLE_WORD;
      end else begin
         last_b_q <= last_b_d;
         word_q   <= word_d;
      end
   end
   assign word_o = word_q;
endmodule

// File: rtl/spi_chan_ctrl.sv
// spi_chan_ctrl: frames received SPI words into length-delimited packets for
// the RX FIFO and feeds MISO words from two TX FIFOs via round-robin.
module spi_chan_ctrl import spi_chan_pkg::*; #(
   parameter logic [WORD_W-1:0] START_WORD = DEF_START_WORD,
   parameter logic [WORD_W-1:0] IDLE_WORD  = DEF_IDLE_WORD,
   parameter int                MAX_LEN    = 255
) (
   input logic            clk,
   input logic            rst,
   spi_chan_ctrl_if.slave bus
);
   localparam logic [WORD_W-1:0] MAX_W = WORD_W'(MAX_LEN);
   rx_state_t         state_q, state_d;
   logic [WORD_W-1:0] cnt_q, cnt_d, data_q, data_d, pkt_q, pkt_d;
   logic              first_q, first_d, wr_q, wr_d, sop_q, sop_d, eop_q, eop_d, drop_q, drop_d;
   logic              last;
   assign last = cnt_q == WORD_W'(1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      data_d  = data_q;
      pkt_d   = pkt_q;
      wr_d    = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      drop_d  = 1'b0;
      if (bus.rx_word_vld) begin
         case (state_q)
            RX_IDLE: state_d = (bus.rx_word == START_WORD) ? RX_LEN : RX_IDLE;
            RX_LEN: begin
               if (bus.rx_word == '0 || bus.rx_word > MAX_W) begin
                  drop_d  = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  cnt_d   = bus.rx_word;
                  first_d = 1'b1;
                  state_d = RX_PAYLOAD;
               end
            end
            RX_PAYLOAD: begin
               cnt_d   = cnt_q - WORD_W'(1);
               first_d = 1'b0;
               if (bus.rxf_full) begin
                  drop_d  = 1'b1;
                  state_d = last ? RX_IDLE : RX_DROP;
               end else begin
                  wr_d    = 1'b1;
                  data_d  = bus.rx_word;
                  sop_d   = first_q;
                  eop_d   = last;
                  pkt_d   = last ? pkt_q + WORD_W'(1) : pkt_q;
                  state_d = last ? RX_IDLE : RX_PAYLOAD;
               end
            end
            RX_DROP: begin
               cnt_d   = cnt_q - WORD_W'(1);
               state_d = last ? RX_IDLE : RX_DROP;
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         first_q <= 1'b0;
         data_q  <= '0;
         pkt_q   <= '0;
         wr_q    <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         data_q  <= data_d;
         pkt_q   <= pkt_d;
         wr_q    <= wr_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         drop_q  <= drop_d;
      end
   end
   assign bus.rxf_data = data_q;
   assign bus.rxf_wr   = wr_q;
   assign bus.rxf_sop  = sop_q;
   assign bus.rxf_eop  = eop_q;
   assign bus.rx_drop  = drop_q;
   assign bus.pkt_cnt  = pkt_q;
   spi_tx_arb #(.IDLE_WORD(IDLE_WORD)) u_tx_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (bus.tx_req),
      .a_data_i  (bus.txa_data),
      .a_empty_i (bus.txa_empty),
      .b_data_i  (bus.txb_data),
      .b_empty_i (bus.txb_empty),
      .a_rd_o    (bus.txa_rd),
      .b_rd_o    (bus.txb_rd),
      .word_o    (bus.tx_word)
   );
endmodule

// File: tb/tb_spi_chan_ctrl.sv
// tb_spi_chan_ctrl: table-driven directed vectors for the SPI packet controller
// with MAX_LEN=4, plus a hand-written mid-packet reset sequence.
module tb_spi_chan_ctrl;
   typedef struct {
      logic        vld;
      logic [15:0] word;
      logic        full;
      logic        req;
      logic        ae;
      logic        be;
      logic [15:0] ad;
      logic [15:0] bd;
      logic        e_wr;
      logic [15:0] e_data;
      logic        e_sop;
      logic        e_eop;
      logic        e_drop;
      logic [15:0] e_pkt;
      logic        e_ard;
      logic        e_brd;
      logic [15:0] e_tx;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   int row = 0;
   vec_t v[$];
   logic [15:0] cur_tx = 16'h0000;
   logic [15:0] cur_pkt = 16'h0000;

   spi_chan_ctrl_if bus ();
   spi_chan_ctrl #(.MAX_LEN(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic rx(input logic [15:0] w, input logic f, input logic wr, sop, eop, drop,
                     input logic [15:0] pkt);
      vec_t r;
      r.vld = 1'b1; r.word = w; r.full = f;
      r.req = 1'b0; r.ae = 1'b1; r.be = 1'b1; r.ad = 16'h0; r.bd = 16'h0;
      r.e_wr = wr; r.e_data = w; r.e_sop = sop; r.e_eop = eop; r.e_drop = drop;
      r.e_pkt = pkt; r.e_ard = 1'b0; r.e_brd = 1'b0; r.e_tx = cur_tx;
      cur_pkt = pkt;
      v.push_back(r);
   endtask

   task automatic idle();
      rx(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_pkt);
      v[v.size() - 1].vld = 1'b0;
   endtask

   task automatic txm(input logic rq, ae, be, input logic [15:0] ad, bd, input logic ard, brd);
      int n;
      n = v.size() - 1;
      v[n].req = rq; v[n].ae = ae; v[n].be = be; v[n].ad = ad; v[n].bd = bd;
      v[n].e_ard = ard; v[n].e_brd = brd;
      cur_tx = ard ? ad : brd ? bd : rq ? 16'h0000 : cur_tx;
      v[n].e_tx = cur_tx;
   endtask

   task automatic tx(input logic rq, ae, be, input logic [15:0] ad, bd, input logic ard, brd);
      idle();
      txm(rq, ae, be, ad, bd, ard, brd);
   endtask

   task automatic drive_quiet();
      bus.rx_word_vld = 1'b0; bus.rx_word = 16'h0; bus.rxf_full = 1'b0;
      bus.tx_req = 1'b0; bus.txa_empty = 1'b1; bus.txb_empty = 1'b1;
      bus.txa_data = 16'h0; bus.txb_data = 16'h0;
   endtask

   task automatic run_table();
      foreach (v[i]) begin
         row = i;
         bus.rx_word_vld = v[i].vld; bus.rx_word = v[i].word; bus.rxf_full = v[i].full;
         bus.tx_req = v[i].req; bus.txa_empty = v[i].ae; bus.txb_empty = v[i].be;
         bus.txa_data = v[i].ad; bus.txb_data = v[i].bd;
         #1;
         chk("txa_rd", 16'(bus.txa_rd), 16'(v[i].e_ard));
         chk("txb_rd", 16'(bus.txb_rd), 16'(v[i].e_brd));
         @(posedge clk);
         #1;
         chk("rxf_wr", 16'(bus.rxf_wr), 16'(v[i].e_wr));
         chk("rx_drop", 16'(bus.rx_drop), 16'(v[i].e_drop));
         chk("pkt_cnt", bus.pkt_cnt, v[i].e_pkt);
         chk("tx_word", bus.tx_word, v[i].e_tx);
         if (v[i].e_wr) begin
            chk("rxf_data", bus.rxf_data, v[i].e_data);
            chk("rxf_sop", 16'(bus.rxf_sop), 16'(v[i].e_sop));
            chk("rxf_eop", 16'(bus.rxf_eop), 16'(v[i].e_eop));
         end
      end
      drive_quiet();
      v.delete();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " rxf_wr"}, 16'(bus.rxf_wr), 16'h0);
      chk({tag, " rxf_sop"}, 16'(bus.rxf_sop), 16'h0);
      chk({tag, " rxf_eop"}, 16'(bus.rxf_eop), 16'h0);
      chk({tag, " rx_drop"}, 16'(bus.rx_drop), 16'h0);
      chk({tag, " rxf_data"}, bus.rxf_data, 16'h0);
      chk({tag, " pkt_cnt"}, bus.pkt_cnt, 16'h0);
      chk({tag, " tx_word"}, bus.tx_word, 16'h0000);
   endtask

   initial begin
      drive_quiet();
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      // three-word packet
      rx(16'h09BB, 0, 0, 0, 0, 0, 0); rx(16'h0003, 0, 0, 0, 0, 0, 0);
      rx(16'h1111, 0, 1, 1, 0, 0, 0); rx(16'h2222, 0, 1, 0, 0, 0, 0);
      rx(16'h3333, 0, 1, 0, 1, 0, 1);
      // junk then single-word packet
      rx(16'h1234, 0, 0, 0, 0, 0, 1); rx(16'h5678, 0, 0, 0, 0, 0, 1);
      rx(16'h09BB, 0, 0, 0, 0, 0, 1); rx(16'h0001, 0, 0, 0, 0, 0, 1);
      rx(16'hABCD, 0, 1, 1, 1, 0, 2);
      idle();
      // bad lengths, then a MAX_LEN packet carrying START_WORD as data
      rx(16'h09BB, 0, 0, 0, 0, 0, 2); rx(16'h0000, 0, 0, 0, 0, 1, 2);
      rx(16'h09BB, 0, 0, 0, 0, 0, 2); rx(16'h0005, 0, 0, 0, 0, 1, 2);
      rx(16'h09BB, 0, 0, 0, 0, 0, 2); rx(16'h0004, 0, 0, 0, 0, 0, 2);
      rx(16'h0A0A, 0, 1, 1, 0, 0, 2); rx(16'h09BB, 0, 1, 0, 0, 0, 2);
      rx(16'h0C0C, 0, 1, 0, 0, 0, 2); rx(16'h0D0D, 0, 1, 0, 1, 0, 3);
      // overflow on 2nd word of 4
      rx(16'h09BB, 0, 0, 0, 0, 0, 3); rx(16'h0004, 0, 0, 0, 0, 0, 3);
      rx(16'h4441, 0, 1, 1, 0, 0, 3); rx(16'h4442, 1, 0, 0, 0, 1, 3);
      rx(16'h4443, 0, 0, 0, 0, 0, 3); rx(16'h4444, 0, 0, 0, 0, 0, 3);
      rx(16'h09BB, 0, 0, 0, 0, 0, 3); rx(16'h0002, 0, 0, 0, 0, 0, 3);
      rx(16'h5551, 0, 1, 1, 0, 0, 3); rx(16'h5552, 0, 1, 0, 1, 0, 4);
      // overflow on the last word goes straight back to idle
      rx(16'h09BB, 0, 0, 0, 0, 0, 4); rx(16'h0001, 0, 0, 0, 0, 0, 4);
      rx(16'h6661, 1, 0, 0, 0, 1, 4);
      rx(16'h09BB, 0, 0, 0, 0, 0, 4); rx(16'h0001, 0, 0, 0, 0, 0, 4);
      rx(16'h7771, 0, 1, 1, 1, 0, 5);
      // TX round-robin
      tx(1, 0, 0, 16'hAAA0, 16'hBBB0, 1, 0);
      tx(1, 0, 0, 16'hAAA1, 16'hBBB0, 0, 1);
      tx(1, 0, 0, 16'hAAA1, 16'hBBB1, 1, 0);
      tx(1, 0, 0, 16'hAAA2, 16'hBBB1, 0, 1);
      tx(0, 0, 0, 16'hAAA2, 16'hBBB2, 0, 0);
      tx(1, 1, 1, 16'hAAA2, 16'hBBB2, 0, 0);
      tx(1, 1, 0, 16'hAAA2, 16'hBBB2, 0, 1);
      tx(1, 1, 0, 16'hAAA2, 16'hBBB3, 0, 1);
      tx(1, 0, 0, 16'hAAA2, 16'hBBB4, 1, 0);
      tx(1, 0, 1, 16'hAAA3, 16'hBBB4, 1, 0);
      tx(1, 0, 0, 16'hAAA4, 16'hBBB4, 0, 1);
      tx(1, 1, 1, 16'hAAA4, 16'hBBB5, 0, 0);
      tx(1, 0, 0, 16'hAAA4, 16'hBBB5, 1, 0);
      run_table();
      // reset in the middle of a payload
      rx(16'h09BB, 0, 0, 0, 0, 0, 5); rx(16'h0003, 0, 0, 0, 0, 0, 5);
      rx(16'h9991, 0, 1, 1, 0, 0, 5);
      run_table();
      #2 rst = 1'b1;
      #1;
      row = -1;
      chk_reset("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cur_tx = 16'h0000;
      @(posedge clk);
      #1;
      rx(16'h09BB, 0, 0, 0, 0, 0, 0); rx(16'h0002, 0, 0, 0, 0, 0, 0);
      rx(16'h8881, 0, 1, 1, 0, 0, 0);
      txm(1, 0, 0, 16'hCCC0, 16'hDDD0, 1, 0);
      rx(16'h8882, 0, 1, 0, 1, 0, 1);
      run_table();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_chan_ctrl.md
# spi_chan_ctrl

Packet controller for the 16-bit SPI slave word channel. Sits between the SPI slave core and the FPGA-side FIFOs. On receive it frames incoming words into length-delimited packets, writes them to the RX FIFO, and drops packets that overflow. On transmit it arbitrates round-robin between a data FIFO and a control FIFO to supply the next MISO word whenever the slave requests one.

## Interface
Parameters:
- `START_WORD`, default 16'h09BB: packet start marker.
- `IDLE_WORD`, default 16'h0000: TX filler word when both sources are empty.
- `MAX_LEN`, default 255: maximum payload length in words, range 1..65535.

Ports:
- `clk` input 1: single clock. Everything is synchronous to its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_word` input 16: word received from the SPI slave.
- `rx_word_vld` input 1: one-cycle strobe qualifying `rx_word`. Back-to-back strobes are legal.
- `rxf_data` output 16: RX FIFO write data.
- `rxf_wr` output 1: RX FIFO write strobe.
- `rxf_sop` output 1: first payload word of the packet. Qualified by `rxf_wr`.
- `rxf_eop` output 1: last payload word of the packet. Qualified by `rxf_wr`.
- `rxf_full` input 1: RX FIFO full.
- `rx_drop` output 1: one-cycle pulse when the current packet is aborted.
- `pkt_cnt` output 16: count of good packets received. Wraps from 16'hFFFF to 0.
- `tx_req` input 1: one-cycle strobe from the slave requesting the next word.
- `txa_data` input 16: data FIFO head (first-word fall-through).
- `txa_empty` input 1: data FIFO empty.
- `txa_rd` output 1: data FIFO read strobe.
- `txb_data` input 16: control FIFO head (first-word fall-through).
- `txb_empty` input 1: control FIFO empty.
- `txb_rd` output 1: control FIFO read strobe.
- `tx_word` output 16: word handed to the slave for shifting out.

## Operation
- RX FSM states are IDLE, LEN, PAYLOAD and DROP. Only cycles with `rx_word_vld`=1 advance the FSM.
- IDLE:
  - A word equal to `START_WORD` moves the FSM to LEN.
  - Any other word is discarded silently.
- LEN: the word is the payload length L.
  - If L=0 or L>`MAX_LEN`: pulse `rx_drop` and return to IDLE.
  - Otherwise load the remaining-word counter with L and go to PAYLOAD.
- PAYLOAD: each word decrements the counter.
  - If `rxf_full`=0: write the word. `rxf_sop` is set on the first word. `rxf_eop` is set when the counter equals 1.
  - After the word with counter=1 is written: increment `pkt_cnt` and go to IDLE.
  - If `rxf_full`=1 when a word arrives: do not write it, pulse `rx_drop`, and go to DROP.
  - If the full word was also the last word (counter=1), go directly to IDLE instead of DROP.
- DROP: consume and discard the remaining words until the counter reaches 0, then go to IDLE. No writes occur and no further `rx_drop` pulses are generated.
- A payload word equal to `START_WORD` is treated as data. There is no resynchronisation inside a packet.
- TX arbitration:
  - On `tx_req`, exactly one of the following applies:
    - Both sources non-empty: grant the source not granted last. After reset, A has priority.
    - Only one source non-empty: grant that source. The last-grant pointer is updated.
    - Both sources empty: output `IDLE_WORD` and leave the pointer unchanged.
  - The granted source receives a `txa_rd` or `txb_rd` pulse in the same cycle as `tx_req`. Its head word is registered into `tx_word`.
- RX and TX paths are independent. Simultaneous `rx_word_vld` and `tx_req` are both serviced in the same cycle.

## Timing
- Reset values:
  - Outputs: `rxf_wr`, `rxf_sop`, `rxf_eop`, `rx_drop`, `txa_rd` and `txb_rd` are all 0. `rxf_data`=0, `pkt_cnt`=0, `tx_word`=`IDLE_WORD`.
  - Internal: FSM=IDLE, last-grant pointer=B (so A wins first).
- RX latency:
  - `rxf_wr`, `rxf_data`, `rxf_sop` and `rxf_eop` are registered and assert 1 cycle after the qualifying `rx_word_vld`.
  - `rx_drop` is also registered, 1 cycle after the triggering word.
  - `rxf_full` is sampled in the same cycle as `rx_word_vld`.
- `pkt_cnt` updates in the same cycle that `rxf_eop` asserts.
- TX timing:
  - `txa_rd` and `txb_rd` are combinational from `tx_req`, the empty flags and the pointer.
  - `tx_word` updates 1 cycle after `tx_req` and holds until the next grant.
- A `tx_req` arriving on consecutive cycles is serviced on every cycle.
- Asserting `rst` mid-packet aborts the packet without an `rx_drop` pulse. It also discards any partial-packet state.

## Structure
- Package `spi_chan_pkg` holds:
  - the default `START_WORD` and `IDLE_WORD`;
  - the RX state encoding (a 2-bit enum);
  - the 16-bit word width constant.
- Sub-module `spi_tx_arb` is the 2:1 round-robin TX arbiter with the `tx_word` register. The RX FSM stays in the top level.

## Test plan
- Packet 09BB, 0003, 1111, 2222, 3333 with `rxf_full`=0 -> three writes with sop on 1111 and eop on 3333; `pkt_cnt`=1.
- Junk words 1234 and 5678, then 09BB, 0001, ABCD -> junk produces no writes; a single write of ABCD with sop=eop=1.
- Length 0000, and separately length `MAX_LEN`+1 -> `rx_drop` pulses, no writes, the FSM returns to IDLE, and the next packet is accepted.
- `rxf_full` raised on the 2nd word of a 4-word payload -> one write (sop, no eop), one `rx_drop` pulse, the remaining 3 words discarded; `pkt_cnt` unchanged; the following packet is received intact.
- Both TX FIFOs non-empty (A=AAA0.., B=BBB0..) with 4 `tx_req` -> `tx_word` sequence AAA0, BBB0, AAA1, BBB1. With both empty -> 0000 and no read strobes.
- `rst` asserted mid-payload, then a new full packet -> outputs return to reset values immediately, and the new packet is received correctly.
